decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter XLEN, default 32: datapath width of register contents, immediates and NPC.
REQ-002 Parameter NREG, default 32: register count; the register address is clog2(NREG) bits wide (AW) and NREG SHALL be at most 32.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 npc_if  in  XLEN  next PC from fetch.
REQ-006 ir_if  in  32  instruction from fetch.
REQ-007 valid_if  in  1  fetch presents a valid instruction.
REQ-008 ready_if  out  1  decode accepts ir_if/npc_if this cycle.
REQ-009 stall_ex  in  1  downstream hold; ID/EX register keeps its value.
REQ-010 flush  in  1  branch-taken squash of the ID/EX contents.
REQ-011 wb_we, wb_addr, wb_data  in  1/AW/XLEN  writeback port into the register bank.
REQ-012 a, b, imm, npc_id  out  XLEN  registered operand A, operand B, sign-extended immediate and NPC.
REQ-013 ir_id  out  32  registered instruction; rd_id  out  AW  registered destination; valid_id  out  1.
REQ-014 hazard  out  1  load-use bubble being inserted this cycle.

Function
REQ-015 Field split SHALL be op=ir[31:26] (6 bits), rd=ir[25:21], rs1=ir[20:16], rs2=ir[15:11], imm16=ir[15:0]; register fields are truncated to AW bits.
REQ-016 imm SHALL be imm16 sign-extended to XLEN.
REQ-017 Register 0 SHALL always read 0; writes to it SHALL be ignored.
REQ-018 Register bank write SHALL occur at the rising edge when wb_we=1 and wb_addr!=0, independent of stall or flush.
REQ-019 Read SHALL bypass: when wb_we=1, wb_addr!=0 and wb_addr equals rs1 (rs2), a (b) SHALL capture wb_data in the same edge.
REQ-020 hazard SHALL be 1 when valid_id=1, op of ir_id equals OP_LW, rd_id!=0, valid_if=1 and rd_id equals rs1 or rs2 of ir_if.
REQ-021 ready_if SHALL equal !(stall_ex | hazard).
REQ-022 ID/EX update priority: flush > stall_ex > hazard > load.
REQ-023 On flush the next state SHALL have valid_id=0 and ir_id=0 (NOP); the other ID/EX outputs are don't-care.
REQ-024 On stall_ex without flush, all ID/EX outputs SHALL hold.
REQ-025 On hazard without stall_ex or flush, the next state SHALL be a bubble (valid_id=0, ir_id=0); the fetch instruction is held upstream and is re-presented.
REQ-026 Otherwise the next state SHALL capture the decoded ir_if/npc_if with valid_id=valid_if, giving one-cycle latency from fetch to outputs.
REQ-027 Flush and hazard in the same cycle SHALL yield a single bubble, and hazard SHALL be recomputed against the flushed (invalid) state.

Reset
REQ-028 While rst_n=0: all registers of the bank, a, b, imm, npc_id, ir_id and rd_id SHALL be 0, and valid_id=0.
REQ-029 A reset asserted mid-stall or mid-hazard SHALL take effect immediately; after release, the block SHALL accept on the first edge with ready_if=1.

Structure
REQ-030 Package decode_pkg SHALL hold the opcode constants (OP_LW=6'b100011, OP_SW, OP_RTYPE), the instruction field bit positions and the NOP value.
REQ-031 The register bank SHALL be the sub-module regfile_2r1w (parameters XLEN and NREG, two async read ports, one write port, x0 hardwired); all other logic resides in decode_pipe.

Verification
REQ-032 Reset, then write 0x1234 to r5 via wb, then ir_if with rs1=5, rs2=0 -> one cycle later a=0x1234, b=0, valid_id=1.
REQ-033 Same-cycle wb_we to r7 of 0xABCD while ir_if reads rs2=7 -> b=0xABCD (bypass), not the old value.
REQ-034 imm16=0x8000, XLEN=32 -> imm=0xFFFF8000; imm16=0x7FFF -> imm=0x00007FFF.
REQ-035 LW with rd=3 in ID followed by an instruction using rs1=3 -> hazard=1, ready_if=0, then one bubble (valid_id=0, ir_id=0), then the dependent instruction is issued.
REQ-036 stall_ex for 3 cycles -> outputs unchanged, ready_if=0; flush together with stall_ex -> valid_id=0 on the next edge.
REQ-037 wb write to r0 of 0xFFFF, then read rs1=0 -> a=0; repeat the suite with XLEN=64, NREG=16.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: opcodes, instruction field
// positions and the NOP encoding.
package decode_pkg;

    // Opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Field positions; register fields are 5 bits wide in the encoding
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned RD_LSB  = 21;
    localparam int unsigned RS1_LSB = 16;
    localparam int unsigned RS2_LSB = 11;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned REG_W   = 5;

    // All-zero word doubles as the bubble/NOP in ID/EX
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/regfile_2r1w.sv
// Register bank: two asynchronous read ports, one synchronous write port.
// Entry 0 reads as zero and ignores writes.
module regfile_2r1w #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    localparam int unsigned AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs_q [NREG];

    // Write port; entry 0 is never written so it stays at its reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Read ports, with address 0 forced to zero
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
    end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: splits the fetched instruction, reads operands (with
// writeback bypass), detects load-use hazards and holds the ID/EX register.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    localparam int unsigned AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    // fetch side
    input  logic [XLEN-1:0] npc_if,
    input  logic [31:0]     ir_if,
    input  logic            valid_if,
    output logic            ready_if,
    // pipeline control
    input  logic            stall_ex,
    input  logic            flush,
    // writeback
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    // ID/EX register
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] npc_id,
    output logic [31:0]     ir_id,
    output logic [AW-1:0]   rd_id,
    output logic            valid_id,
    output logic            hazard
);

    logic [AW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;
    logic            wb_hit1, wb_hit2;

    logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, npc_q, npc_d;
    logic [31:0]     ir_q, ir_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic            valid_q, valid_d;

    // Register fields truncated to the bank's address width
    assign rd  = ir_if[RD_LSB  +: AW];
    assign rs1 = ir_if[RS1_LSB +: AW];
    assign rs2 = ir_if[RS2_LSB +: AW];

    regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (rs1),
        .rdata1 (rf_rdata1),
        .raddr2 (rs2),
        .rdata2 (rf_rdata2),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    // Hazard/ready and same-cycle writeback forwarding
    always_comb begin
        hazard   = valid_q && (ir_q[OP_LSB +: OP_W] == OP_LW) && (rd_q != '0) && valid_if &&
                   ((rd_q == rs1) || (rd_q == rs2));
        ready_if = !(stall_ex || hazard);
        wb_hit1  = wb_we && (wb_addr != '0) && (wb_addr == rs1);
        wb_hit2  = wb_we && (wb_addr != '0) && (wb_addr == rs2);
    end

    // ID/EX next state, priority flush > stall > hazard > load
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        npc_d   = npc_q;
        ir_d    = ir_q;
        rd_d    = rd_q;
        valid_d = valid_q;
        if (flush || (!stall_ex && hazard)) begin
            // Squash or bubble; operand fields are don't-care and simply hold
            valid_d = 1'b0;
            ir_d    = NOP_INSTR;
            rd_d    = '0;
        end else if (!stall_ex) begin
            a_d     = wb_hit1 ? wb_data : rf_rdata1;
            b_d     = wb_hit2 ? wb_data : rf_rdata2;
            imm_d   = {{(XLEN-IMM_W){ir_if[IMM_LSB+IMM_W-1]}}, ir_if[IMM_LSB +: IMM_W]};
            npc_d   = npc_if;
            ir_d    = ir_if;
            rd_d    = rd;
            valid_d = valid_if;
        end
    end

    // ID/EX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            npc_q   <= '0;
            ir_q    <= NOP_INSTR;
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            npc_q   <= npc_d;
            ir_q    <= ir_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign imm      = imm_q;
    assign npc_id   = npc_q;
    assign ir_id    = ir_q;
    assign rd_id    = rd_q;
    assign valid_id = valid_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: drives a 32-bit/32-reg and a
// 64-bit/16-reg instance with identical stimulus and checks both.
module tb_decode_pipe;
    import decode_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [63:0] npc_if;
    logic [31:0] ir_if;
    logic        valid_if, stall_ex, flush, wb_we;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;

    logic [31:0] a32, b32, imm32, npc32, ir32;
    logic [4:0]  rd32;
    logic        ready32, valid32, hazard32;
    logic [63:0] a64, b64, imm64, npc64;
    logic [31:0] ir64;
    logic [3:0]  rd64;
    logic        ready64, valid64, hazard64;

    int n_checks = 0;
    int n_errors = 0;

    decode_pipe #(.XLEN(32), .NREG(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .npc_if(npc_if[31:0]), .ir_if(ir_if),
        .valid_if(valid_if), .ready_if(ready32), .stall_ex(stall_ex), .flush(flush),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data[31:0]),
        .a(a32), .b(b32), .imm(imm32), .npc_id(npc32), .ir_id(ir32), .rd_id(rd32),
        .valid_id(valid32), .hazard(hazard32)
    );

    decode_pipe #(.XLEN(64), .NREG(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .npc_if(npc_if), .ir_if(ir_if),
        .valid_if(valid_if), .ready_if(ready64), .stall_ex(stall_ex), .flush(flush),
        .wb_we(wb_we), .wb_addr(wb_addr[3:0]), .wb_data(wb_data),
        .a(a64), .b(b64), .imm(imm64), .npc_id(npc64), .ir_id(ir64), .rd_id(rd64),
        .valid_id(valid64), .hazard(hazard64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // 32-bit instance is compared against the low half of the 64-bit expectation
    task automatic chk2(input string tag, input logic [63:0] got32, input logic [63:0] got64,
                        input logic [63:0] exp);
        check({tag, "/x32"}, got32, {32'h0, exp[31:0]});
        check({tag, "/x64"}, got64, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_r(logic [5:0] op, logic [4:0] rd, logic [4:0] rs1,
                                         logic [4:0] rs2);
        return {op, rd, rs1, rs2, 11'h0};
    endfunction

    function automatic logic [31:0] mk_i(logic [5:0] op, logic [4:0] rd, logic [4:0] rs1,
                                         logic [15:0] im);
        return {op, rd, rs1, im};
    endfunction

    task automatic fetch(input logic [31:0] ir, input logic [63:0] npc);
        ir_if    = ir;
        npc_if   = npc;
        valid_if = 1'b1;
    endtask

    task automatic wb(input logic we, input logic [4:0] addr, input logic [63:0] data);
        wb_we   = we;
        wb_addr = addr;
        wb_data = data;
    endtask

    logic [31:0] ins_x, ins_y, ins_dep;

    initial begin
        rst_n = 1'b0; npc_if = '0; ir_if = '0; valid_if = 1'b0;
        stall_ex = 1'b0; flush = 1'b0; wb(1'b0, 5'd0, 64'h0);
        ins_x   = mk_r(OP_RTYPE, 5'd6, 5'd5, 5'd0);
        ins_y   = mk_r(OP_RTYPE, 5'd8, 5'd7, 5'd0);
        ins_dep = mk_r(OP_RTYPE, 5'd4, 5'd3, 5'd0);

        // Reset state
        #2;
        chk2("rst_valid", 64'(valid32), 64'(valid64), 64'h0);
        chk2("rst_a", 64'(a32), a64, 64'h0);
        chk2("rst_ir", 64'(ir32), 64'(ir64), 64'h0);
        chk2("rst_ready", 64'(ready32), 64'(ready64), 64'h1);
        tick(); tick();
        rst_n = 1'b1;

        // Writeback r5, then read it through rs1
        wb(1'b1, 5'd5, 64'h1234);
        tick();
        wb(1'b0, 5'd0, 64'h0);
        fetch(mk_r(OP_RTYPE, 5'd1, 5'd5, 5'd0), 64'h100);
        tick();
        chk2("rd5_a", 64'(a32), a64, 64'h1234);
        chk2("rd5_b", 64'(b32), b64, 64'h0);
        chk2("rd5_valid", 64'(valid32), 64'(valid64), 64'h1);
        chk2("rd5_npc", 64'(npc32), npc64, 64'h100);
        chk2("rd5_rd", 64'(rd32), 64'(rd64), 64'h1);

        // Same-edge bypass: r7 holds 0x1111, fetch reads rs2=7 while 0xABCD is written
        valid_if = 1'b0;
        wb(1'b1, 5'd7, 64'h1111);
        tick();
        fetch(mk_r(OP_RTYPE, 5'd2, 5'd0, 5'd7), 64'h104);
        wb(1'b1, 5'd7, 64'hABCD);
        tick();
        chk2("byp_b", 64'(b32), b64, 64'hABCD);
        chk2("byp_a", 64'(a32), a64, 64'h0);
        wb(1'b0, 5'd0, 64'h0);
        fetch(mk_r(OP_RTYPE, 5'd2, 5'd7, 5'd0), 64'h108);
        tick();
        chk2("byp_kept", 64'(a32), a64, 64'hABCD);

        // Sign extension of the immediate
        fetch(mk_i(OP_SW, 5'd0, 5'd0, 16'h8000), 64'h10C);
        tick();
        chk2("imm_neg", 64'(imm32), imm64, 64'hFFFF_FFFF_FFFF_8000);
        fetch(mk_i(OP_SW, 5'd0, 5'd0, 16'h7FFF), 64'h110);
        tick();
        chk2("imm_pos", 64'(imm32), imm64, 64'h0000_0000_0000_7FFF);

        // Load-use: LW r3 then a reader of r3; r3 written meanwhile by wb
        fetch(mk_i(OP_LW, 5'd3, 5'd0, 16'h0004), 64'h114);
        wb(1'b1, 5'd3, 64'h33);
        tick();
        wb(1'b0, 5'd0, 64'h0);
        fetch(ins_dep, 64'h118);
        #1;
        chk2("lu_hazard", 64'(hazard32), 64'(hazard64), 64'h1);
        chk2("lu_ready", 64'(ready32), 64'(ready64), 64'h0);
        tick();
        chk2("lu_bub_valid", 64'(valid32), 64'(valid64), 64'h0);
        chk2("lu_bub_ir", 64'(ir32), 64'(ir64), 64'h0);
        chk2("lu_bub_hazard", 64'(hazard32), 64'(hazard64), 64'h0);
        chk2("lu_bub_ready", 64'(ready32), 64'(ready64), 64'h1);
        tick();
        chk2("lu_issue_valid", 64'(valid32), 64'(valid64), 64'h1);
        chk2("lu_issue_ir", 64'(ir32), 64'(ir64), 64'(ins_dep));
        chk2("lu_issue_a", 64'(a32), a64, 64'h33);
        chk2("lu_issue_rd", 64'(rd32), 64'(rd64), 64'h4);

        // LW to r0 never causes a hazard
        fetch(mk_i(OP_LW, 5'd0, 5'd0, 16'h0), 64'h11C);
        tick();
        fetch(mk_r(OP_RTYPE, 5'd1, 5'd0, 5'd0), 64'h120);
        #1;
        chk2("lw_r0_hazard", 64'(hazard32), 64'(hazard64), 64'h0);

        // Stall for three cycles, then flush under stall
        fetch(ins_x, 64'h200);
        tick();
        stall_ex = 1'b1;
        fetch(ins_y, 64'h204);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk2("stall_ready", 64'(ready32), 64'(ready64), 64'h0);
            tick();
            chk2("stall_ir", 64'(ir32), 64'(ir64), 64'(ins_x));
            chk2("stall_a", 64'(a32), a64, 64'h1234);
            chk2("stall_npc", 64'(npc32), npc64, 64'h200);
            chk2("stall_valid", 64'(valid32), 64'(valid64), 64'h1);
        end
        flush = 1'b1;
        tick();
        chk2("flush_valid", 64'(valid32), 64'(valid64), 64'h0);
        chk2("flush_ir", 64'(ir32), 64'(ir64), 64'h0);
        stall_ex = 1'b0;
        flush = 1'b0;
        tick();
        chk2("resume_valid", 64'(valid32), 64'(valid64), 64'h1);
        chk2("resume_ir", 64'(ir32), 64'(ir64), 64'(ins_y));
        chk2("resume_a", 64'(a32), a64, 64'hABCD);

        // Writes to r0 are dropped and never bypassed
        fetch(mk_r(OP_RTYPE, 5'd1, 5'd0, 5'd0), 64'h300);
        wb(1'b1, 5'd0, 64'hFFFF);
        tick();
        chk2("r0_byp_a", 64'(a32), a64, 64'h0);
        wb(1'b0, 5'd0, 64'h0);
        tick();
        chk2("r0_a", 64'(a32), a64, 64'h0);
        chk2("r0_b", 64'(b32), b64, 64'h0);

        // Asynchronous reset in the middle of a stall
        fetch(ins_x, 64'h400);
        tick();
        stall_ex = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk2("mid_rst_valid", 64'(valid32), 64'(valid64), 64'h0);
        chk2("mid_rst_a", 64'(a32), a64, 64'h0);
        chk2("mid_rst_ir", 64'(ir32), 64'(ir64), 64'h0);
        stall_ex = 1'b0;
        tick();
        rst_n = 1'b1;
        fetch(ins_x, 64'h500);
        #1;
        chk2("post_rst_ready", 64'(ready32), 64'(ready64), 64'h1);
        tick();
        chk2("post_rst_valid", 64'(valid32), 64'(valid64), 64'h1);
        chk2("post_rst_a", 64'(a32), a64, 64'h0);
        chk2("post_rst_npc", 64'(npc32), npc64, 64'h500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
